poly_mul_sequencer: RTL and testbench
=====================================

POLY_MUL_SEQUENCER -- requirements
Module: poly_mul_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the per-step cycle limit while waiting for core completion.
REQ-002 Parameter CLR_CYCLES, default 2, SHALL set how many cycles core_rst is held low before each step.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to run the sequence selected by mode; sampled only in IDLE.
REQ-006 mode  input  2  00 full poly-mul, 01 NTT only, 10 INTT only, 11 pointwise only; captured with start.
REQ-007 abort  input  1  cancels any sequence in progress.
REQ-008 done_flag  input  4  core completion flags: bit0 NTT, bit1 INTT, bit2 pointwise; bit3 ignored.
REQ-009 conf  output  3  core operation: 0 idle, 1 NTT, 2 INTT, 3 pointwise.
REQ-010 core_rst  output  1  active-low restart for the core FSM, twiddle-address generator and pipelines.
REQ-011 op_sel  output  2  operand bank set: 0 operand A, 1 operand B, 2 result.
REQ-012 busy  output  1  high while a sequence is in progress.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 err  output  1  sticky timeout flag.
REQ-015 step  output  2  index of the current step within the sequence.

Function
REQ-016 Step lists SHALL be: mode 00 = {NTT/op 0, NTT/op 1, pointwise/op 2, INTT/op 2}; 01 = {NTT/op 0}; 10 = {INTT/op 0}; 11 = {pointwise/op 2}.
REQ-017 States SHALL be IDLE, CLR, RUN, GAP, FIN.
REQ-018 IDLE: conf=0, core_rst=1, busy=0; start=1 and abort=0 SHALL latch mode, clear err, set step=0, and enter CLR on the next cycle.
REQ-019 CLR: core_rst=0, conf/op_sel SHALL be driven for the current step; after exactly CLR_CYCLES cycles, enter RUN.
REQ-020 RUN: core_rst=1, conf/op_sel held; the timeout counter SHALL increment every cycle from 0.
REQ-021 In RUN, assertion of the done_flag bit matching the current conf SHALL enter GAP on the next edge; non-matching bits SHALL be ignored.
REQ-022 done_flag SHALL be ignored in every state other than RUN.
REQ-023 GAP (1 cycle): conf=0, core_rst=1; if more steps remain, step SHALL increment and the FSM SHALL enter CLR, otherwise it SHALL enter FIN.
REQ-024 FIN (1 cycle): done=1, busy=0, conf=0; then IDLE.
REQ-025 busy SHALL be 1 in CLR, RUN and GAP, and 0 otherwise.
REQ-026 If the timeout counter reaches TIMEOUT_CYCLES-1 in RUN without the matching flag, err SHALL be set, done SHALL NOT pulse, and the FSM SHALL enter IDLE with core_rst=0 for that cycle.
REQ-027 If the matching flag and the timeout arrive on the same cycle, completion SHALL win.
REQ-028 abort=1 in any non-IDLE state SHALL enter IDLE on the next edge, drive core_rst=0 for one cycle, leave err unchanged, and not pulse done.
REQ-029 If abort and start are both high in IDLE, abort SHALL win and start SHALL be ignored.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 Minimum latency from start to done for a single step SHALL be 1 + CLR_CYCLES + (cycles in RUN) + 1 (GAP) + 1 (FIN).

Reset
REQ-032 While rst=0 at a clock edge, the FSM SHALL enter IDLE with conf=0, core_rst=0, op_sel=0, busy=0, done=0, err=0, step=0, timeout counter=0, and latched mode=00.
REQ-033 core_rst SHALL return to 1 on the first cycle after rst is released.
REQ-034 Reset mid-sequence SHALL discard all progress, with no done pulse.

Verification
REQ-035 Mode 01, done_flag bit0 asserted 10 cycles into RUN -> conf=1 and op_sel=0 throughout, core_rst low for 2 cycles, done pulses exactly once, busy deasserts in the FIN cycle.
REQ-036 Mode 00 with the model core responding after 20 cycles -> conf sequence 1,1,3,2, op_sel sequence 0,1,2,2, step 0..3, one done pulse, four core_rst low windows.
REQ-037 Mode 10, no done_flag -> err=1 at TIMEOUT_CYCLES cycles into RUN, no done pulse, return to IDLE; the next start clears err.
REQ-038 Mode 00, abort during step 2 RUN -> IDLE next cycle, core_rst=0 for one cycle, conf=0, no done; a second start in the same cycle as abort is ignored.
REQ-039 Mode 11 with done_flag=4'b0001 (wrong bit) held, then 4'b0100 -> only bit2 completes; start pulsed while busy has no effect.
REQ-040 rst=0 asserted during step 1 RUN of mode 00 -> all outputs at reset values on the next cycle; no done pulse follows.

Source files
------------

// File: rtl/poly_mul_sequencer.sv
// Sequences a polynomial-multiply core through NTT / pointwise / INTT steps,
// restarting the core before each step and timing out a core that never finishes.
module poly_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLR_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic [3:0] done_flag,
  output logic [2:0] conf,
  output logic       core_rst,
  output logic [1:0] op_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] step,
  output logic [2:0] state_dbg
);

  // Handshake: start is a level sampled only in IDLE (no queuing); done is a
  // one-cycle pulse; the core reports completion by raising its done_flag bit
  // while core_rst=1 and conf is non-zero.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  state_t          state;
  logic [1:0]      mode_q;
  logic [TW-1:0]   tmo_cnt;
  logic [CW-1:0]   clr_cnt;
  logic            flag_hit;

  assign state_dbg = state;

  function automatic logic [2:0] step_conf(input logic [1:0] m, input logic [1:0] s);
    logic [2:0] c;
    c = 3'd0;
    case (m)
      2'b00: begin
        case (s)
          2'd0:    c = 3'd1;
          2'd1:    c = 3'd1;
          2'd2:    c = 3'd3;
          default: c = 3'd2;
        endcase
      end
      2'b01:   c = 3'd1;
      2'b10:   c = 3'd2;
      default: c = 3'd3;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] step_op(input logic [1:0] m, input logic [1:0] s);
    logic [1:0] o;
    o = 2'd0;
    case (m)
      2'b00:   o = (s == 2'd0) ? 2'd0 : (s == 2'd1) ? 2'd1 : 2'd2;
      2'b11:   o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] m);
    return (m == 2'b00) ? 2'd3 : 2'd0;
  endfunction

  // Only the flag belonging to the operation currently configured counts.
  always_comb begin
    flag_hit = 1'b0;
    case (conf)
      3'd1:    flag_hit = done_flag[0];
      3'd2:    flag_hit = done_flag[1];
      3'd3:    flag_hit = done_flag[2];
      default: flag_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      conf     <= 3'd0;
      core_rst <= 1'b0;
      op_sel   <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      step     <= 2'd0;
      mode_q   <= 2'b00;
      tmo_cnt  <= '0;
      clr_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Abort leaves err alone and pulses the core restart for one cycle.
        state    <= S_IDLE;
        conf     <= 3'd0;
        core_rst <= 1'b0;
        op_sel   <= 2'd0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              mode_q   <= mode;
              err      <= 1'b0;
              step     <= 2'd0;
              conf     <= step_conf(mode, 2'd0);
              op_sel   <= step_op(mode, 2'd0);
              core_rst <= 1'b0;
              busy     <= 1'b1;
              clr_cnt  <= '0;
              state    <= S_CLR;
            end else begin
              conf     <= 3'd0;
              core_rst <= 1'b1;
              busy     <= 1'b0;
            end
          end
          S_CLR: begin
            if (clr_cnt == CLR_LAST) begin
              core_rst <= 1'b1;
              tmo_cnt  <= '0;
              state    <= S_RUN;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          S_RUN: begin
            // Completion is checked first so it wins over a coincident timeout.
            if (flag_hit) begin
              conf  <= 3'd0;
              state <= S_GAP;
            end else if (tmo_cnt == TMO_LAST) begin
              err      <= 1'b1;
              conf     <= 3'd0;
              op_sel   <= 2'd0;
              core_rst <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (step != last_step(mode_q)) begin
              step     <= step + 2'd1;
              conf     <= step_conf(mode_q, step + 2'd1);
              op_sel   <= step_op(mode_q, step + 2'd1);
              core_rst <= 1'b0;
              clr_cnt  <= '0;
              state    <= S_CLR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end
          end
          S_FIN: begin
            state <= S_IDLE;
          end
          default: begin
            conf     <= 3'd0;
            core_rst <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_mul_sequencer.sv
// Directed bench for poly_mul_sequencer: a scripted core model answers each step
// and a negedge monitor records conf/op_sel/step sequences, done pulses and core_rst windows.
module tb_poly_mul_sequencer;

  localparam int TMO = 64;
  localparam int CLR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       abort;
  logic [3:0] done_flag;
  logic [2:0] conf;
  logic       core_rst;
  logic [1:0] op_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] step;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  int done_cnt, low_win, low_cyc;
  logic prev_core_rst = 1'b0;
  logic [2:0] prev_conf = 3'd0;
  logic [2:0] conf_q[$];
  logic [1:0] op_q[$];
  logic [1:0] step_q[$];
  logic [2:0] exp_conf_q[$];
  logic [1:0] exp_op_q[$];
  logic [3:0] mask_q[$];

  poly_mul_sequencer #(.TIMEOUT_CYCLES(TMO), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .done_flag(done_flag), .conf(conf), .core_rst(core_rst), .op_sel(op_sel),
    .busy(busy), .done(done), .err(err), .step(step), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (prev_core_rst && !core_rst) low_win++;
      if (!core_rst) low_cyc++;
      if (prev_conf == 3'd0 && conf != 3'd0) begin
        conf_q.push_back(conf);
        op_q.push_back(op_sel);
        step_q.push_back(step);
      end
    end
    prev_core_rst = core_rst;
    prev_conf = conf;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0;
    low_win = 0;
    low_cyc = 0;
    conf_q.delete();
    op_q.delete();
    step_q.delete();
  endtask

  // RUN is the only state with busy=1, core_rst=1 and a non-zero conf.
  task automatic wait_run(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b1 && core_rst === 1'b1 && conf != 3'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_reach_run"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic kick(input logic [1:0] m);
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic respond(input string tag, input int delay, input logic [3:0] mask);
    wait_run(tag);
    repeat (delay) tick();
    done_flag = mask;
    tick();
    done_flag = 4'd0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'b00; abort = 1'b0; done_flag = 4'd0;
    clear_mon();
    repeat (3) tick();
    check("rst_conf", {29'd0, conf}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd0);
    check("rst_op_sel", {30'd0, op_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_step", {30'd0, step}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;
    tick();
    check("rel_core_rst", {31'd0, core_rst}, 32'd1);

    // Mode 01: single NTT step, core answers 10 cycles into RUN.
    clear_mon();
    kick(2'b01);
    check("m1_clr_conf", {29'd0, conf}, 32'd1);
    check("m1_clr_core_rst", {31'd0, core_rst}, 32'd0);
    check("m1_clr_busy", {31'd0, busy}, 32'd1);
    wait_run("m1");
    repeat (10) tick();
    check("m1_run_conf", {29'd0, conf}, 32'd1);
    check("m1_run_op", {30'd0, op_sel}, 32'd0);
    done_flag = 4'b0001;
    tick();
    done_flag = 4'd0;
    check("m1_gap_conf", {29'd0, conf}, 32'd0);
    check("m1_gap_busy", {31'd0, busy}, 32'd1);
    check("m1_gap_done", {31'd0, done}, 32'd0);
    tick();
    check("m1_fin_done", {31'd0, done}, 32'd1);
    check("m1_fin_busy", {31'd0, busy}, 32'd0);
    tick();
    check("m1_idle_done", {31'd0, done}, 32'd0);
    check("m1_done_cnt", done_cnt, 32'd1);
    check("m1_low_cyc", low_cyc, 32'd2);
    check("m1_conf_q_n", conf_q.size(), 32'd1);

    // Mode 00: full sequence, core answers 20 cycles into each RUN.
    clear_mon();
    exp_conf_q = '{3'd1, 3'd1, 3'd3, 3'd2};
    exp_op_q = '{2'd0, 2'd1, 2'd2, 2'd2};
    mask_q = '{4'b0001, 4'b0001, 4'b0100, 4'b0010};
    kick(2'b00);
    for (int s = 0; s < 4; s++) respond("m0", 20, mask_q[s]);
    tick();
    check("m0_fin_done", {31'd0, done}, 32'd1);
    tick();
    check("m0_done_cnt", done_cnt, 32'd1);
    check("m0_low_win", low_win, 32'd4);
    check("m0_low_cyc", low_cyc, 32'd8);
    check("m0_conf_q_n", conf_q.size(), 32'd4);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("m0_conf_%0d", s), {29'd0, conf_q[s]}, {29'd0, exp_conf_q[s]});
      check($sformatf("m0_op_%0d", s), {30'd0, op_q[s]}, {30'd0, exp_op_q[s]});
      check($sformatf("m0_step_%0d", s), {30'd0, step_q[s]}, s);
    end

    // Mode 10: INTT with only non-matching flags present -> timeout.
    clear_mon();
    kick(2'b10);
    done_flag = 4'b1001;
    wait_run("m2");
    repeat (TMO - 1) tick();
    check("m2_pre_err", {31'd0, err}, 32'd0);
    check("m2_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    check("m2_err", {31'd0, err}, 32'd1);
    check("m2_to_core_rst", {31'd0, core_rst}, 32'd0);
    check("m2_to_busy", {31'd0, busy}, 32'd0);
    check("m2_to_conf", {29'd0, conf}, 32'd0);
    done_flag = 4'd0;
    tick();
    check("m2_idle_core_rst", {31'd0, core_rst}, 32'd1);
    check("m2_err_sticky", {31'd0, err}, 32'd1);
    check("m2_done_cnt", done_cnt, 32'd0);
    kick(2'b01);
    check("m2_err_cleared", {31'd0, err}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("m2_abort_busy", {31'd0, busy}, 32'd0);
    tick();

    // Abort and start together in IDLE: nothing starts.
    abort = 1'b1; start = 1'b1; mode = 2'b00;
    tick();
    abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_core_rst", {31'd0, core_rst}, 32'd1);

    // Mode 00 aborted in step 2 RUN, with start raised alongside abort.
    clear_mon();
    kick(2'b00);
    respond("ab", 5, 4'b0001);
    respond("ab", 5, 4'b0001);
    wait_run("ab2");
    check("ab_step", {30'd0, step}, 32'd2);
    check("ab_conf", {29'd0, conf}, 32'd3);
    repeat (3) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_conf_idle", {29'd0, conf}, 32'd0);
    check("ab_core_rst", {31'd0, core_rst}, 32'd0);
    check("ab_err", {31'd0, err}, 32'd0);
    tick();
    check("ab_core_rst_back", {31'd0, core_rst}, 32'd1);
    check("ab_no_restart", {31'd0, busy}, 32'd0);
    check("ab_done_cnt", done_cnt, 32'd0);

    // Mode 11: wrong flag held, start while busy, then the pointwise flag.
    clear_mon();
    kick(2'b11);
    wait_run("m3");
    done_flag = 4'b0001;
    repeat (10) tick();
    check("m3_wrong_busy", {31'd0, busy}, 32'd1);
    check("m3_wrong_conf", {29'd0, conf}, 32'd3);
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("m3_busy_start_step", {30'd0, step}, 32'd0);
    check("m3_busy_start_op", {30'd0, op_sel}, 32'd2);
    done_flag = 4'b0100;
    tick();
    done_flag = 4'd0;
    check("m3_gap_conf", {29'd0, conf}, 32'd0);
    tick();
    check("m3_fin_done", {31'd0, done}, 32'd1);
    repeat (2) tick();
    check("m3_no_queue", {31'd0, busy}, 32'd0);
    check("m3_done_cnt", done_cnt, 32'd1);

    // Reset during step 1 RUN of mode 00.
    clear_mon();
    kick(2'b00);
    respond("rs", 5, 4'b0001);
    wait_run("rs1");
    check("rs_step", {30'd0, step}, 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rs_conf", {29'd0, conf}, 32'd0);
    check("rs_core_rst", {31'd0, core_rst}, 32'd0);
    check("rs_op_sel", {30'd0, op_sel}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_step0", {30'd0, step}, 32'd0);
    check("rs_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;
    done_flag = 4'b0111;
    repeat (5) tick();
    done_flag = 4'd0;
    check("rs_idle_busy", {31'd0, busy}, 32'd0);
    check("rs_idle_core_rst", {31'd0, core_rst}, 32'd1);
    check("rs_done_cnt", done_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
